// File: rtl/fault_monitor_pkg.sv
// Shared motor-fault package: severity level encoding and RMS feature width
// used by fault_monitor and its persistence counter.
package fault_monitor_pkg;

    localparam int RMS_W = 32;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_WARN   = 2'd1,
        ST_FAULT  = 2'd2
    } level_t;

endpackage

// File: rtl/fault_monitor_persist_counter.sv
// persist_counter: tracks the level a run of valid samples is heading towards
// and how many consecutive qualifying samples have been seen. Raises o_commit
// on the sample that completes a run of DEBOUNCE_N, with o_pending giving the
// level the state register should load on that edge.
module persist_counter
    import fault_monitor_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  logic   i_flush,
    input  level_t i_candidate,
    input  level_t i_state,
    output logic   o_commit,
    output level_t o_pending
);

    localparam logic [7:0] RUN_LEN = 8'(DEBOUNCE_N);

    level_t     r_pending;
    logic [7:0] r_count;
    level_t     w_pendingNext;
    logic [7:0] w_countNext;

    // Next pending level and run length; a completed run commits and restarts at zero
    always_comb begin
        w_pendingNext = r_pending;
        w_countNext   = r_count;
        o_commit      = 1'b0;
        if (i_flush) begin
            w_pendingNext = ST_NORMAL;
            w_countNext   = 8'd0;
        end else if (i_valid) begin
            if (i_candidate == i_state) begin
                w_countNext = 8'd0;
            end else if (i_candidate == r_pending) begin
                w_countNext = r_count + 8'd1;
            end else begin
                w_pendingNext = i_candidate;
                w_countNext   = 8'd1;
            end
            if ((i_candidate != i_state) && (w_countNext == RUN_LEN)) begin
                o_commit    = 1'b1;
                w_countNext = 8'd0;
            end
        end
    end

    assign o_pending = w_pendingNext;

    // Pending level and run length registers; reset discards any partial run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= ST_NORMAL;
            r_count   <= 8'd0;
        end else begin
            r_pending <= w_pendingNext;
            r_count   <= w_countNext;
        end
    end

endmodule

// File: rtl/fault_monitor.sv
// fault_monitor: classifies RMS samples into NORMAL/WARN/FAULT with
// hysteresis, debounces level changes through persist_counter and reports
// the registered state, decodes, change pulse and a saturating fault count.
// Optional macro FAULT_LATCH_EN makes FAULT sticky until clear_fault.
module fault_monitor
    import fault_monitor_pkg::*;
#(
    parameter logic [RMS_W-1:0] WARN_TH    = 32'd1000,
    parameter logic [RMS_W-1:0] FAULT_TH   = 32'd4000,
    parameter logic [RMS_W-1:0] HYST       = 32'd100,
    parameter int               DEBOUNCE_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RMS_W-1:0] rms,
    input  logic             rms_valid,
    input  logic             clear_fault,
    output logic [1:0]       state,
    output logic             warn,
    output logic             fault,
    output logic             event_valid,
    output logic [7:0]       fault_count
);

    localparam logic [RMS_W-1:0] WARN_EXIT  = WARN_TH - HYST;
    localparam logic [RMS_W-1:0] FAULT_EXIT = FAULT_TH - HYST;

    level_t     r_state;
    logic       r_warn;
    logic       r_fault;
    logic       r_event;
    logic [7:0] r_faultCount;

    level_t     w_candidate;
    level_t     w_stateNext;
    level_t     w_pending;
    logic       w_commit;
    logic       w_clearFault;
    logic       w_sampleValid;

`ifdef FAULT_LATCH_EN
    assign w_clearFault = clear_fault && (r_state == ST_FAULT);
`else
    logic w_unusedClear;
    assign w_unusedClear = clear_fault;
    assign w_clearFault  = 1'b0;
`endif

    // An acknowledge takes precedence, so a sample arriving with it is dropped
    assign w_sampleValid = rms_valid && !w_clearFault;

    // Candidate level for the current sample, with hysteresis on the way down
    always_comb begin
        w_candidate = r_state;
        case (r_state)
            ST_NORMAL: begin
                if (rms >= FAULT_TH)     w_candidate = ST_FAULT;
                else if (rms >= WARN_TH) w_candidate = ST_WARN;
                else                     w_candidate = ST_NORMAL;
            end
            ST_WARN: begin
                if (rms >= FAULT_TH)       w_candidate = ST_FAULT;
                else if (rms < WARN_EXIT)  w_candidate = ST_NORMAL;
                else                       w_candidate = ST_WARN;
            end
            ST_FAULT: begin
`ifdef FAULT_LATCH_EN
                w_candidate = ST_FAULT;
`else
                if (rms < WARN_EXIT)       w_candidate = ST_NORMAL;
                else if (rms < FAULT_EXIT) w_candidate = ST_WARN;
                else                       w_candidate = ST_FAULT;
`endif
            end
            default: w_candidate = ST_NORMAL;
        endcase
    end

    persist_counter #(
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_persist (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_sampleValid),
        .i_flush     (w_clearFault),
        .i_candidate (w_candidate),
        .i_state     (r_state),
        .o_commit    (w_commit),
        .o_pending   (w_pending)
    );

    // Next state: acknowledge forces NORMAL, otherwise a completed run loads pending
    always_comb begin
        w_stateNext = r_state;
        if (w_clearFault)  w_stateNext = ST_NORMAL;
        else if (w_commit) w_stateNext = w_pending;
    end

    // State register with registered decodes, change pulse and fault entry count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_NORMAL;
            r_warn       <= 1'b0;
            r_fault      <= 1'b0;
            r_event      <= 1'b0;
            r_faultCount <= 8'd0;
        end else begin
            r_state <= w_stateNext;
            r_warn  <= (w_stateNext == ST_WARN);
            r_fault <= (w_stateNext == ST_FAULT);
            r_event <= (w_stateNext != r_state);
            if ((w_stateNext == ST_FAULT) && (r_state != ST_FAULT) && (r_faultCount != 8'hFF))
                r_faultCount <= r_faultCount + 8'd1;
        end
    end

    assign state       = r_state;
    assign warn        = r_warn;
    assign fault       = r_fault;
    assign event_valid = r_event;
    assign fault_count = r_faultCount;

endmodule

// File: tb/tb_fault_monitor.sv
// Testbench for fault_monitor with default parameters. Honours FAULT_LATCH_EN
// in the same way as the design.
module tb_fault_monitor;

    localparam int unsigned WARN_TH  = 1000;
    localparam int unsigned FAULT_TH = 4000;
    localparam int unsigned HYST     = 100;
    localparam int          N        = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rms = 32'd0;
    logic        rms_valid = 1'b0;
    logic        clear_fault = 1'b0;
    logic [1:0]  state;
    logic        warn;
    logic        fault;
    logic        event_valid;
    logic [7:0]  fault_count;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: current level, run towards another level, fault entries
    int mState      = 0;
    int mRunLvl     = 0;
    int mRun        = 0;
    int mEvent      = 0;
    int mFaultCount = 0;

    fault_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .rms         (rms),
        .rms_valid   (rms_valid),
        .clear_fault (clear_fault),
        .state       (state),
        .warn        (warn),
        .fault       (fault),
        .event_valid (event_valid),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    // Level a sample points to, given the current level
    function automatic int classify(input int unsigned v, input int cur);
`ifdef FAULT_LATCH_EN
        if (cur == 2) return 2;
`endif
        if (cur == 0) return (v >= FAULT_TH) ? 2 : (v >= WARN_TH) ? 1 : 0;
        if (cur == 1) return (v >= FAULT_TH) ? 2 : (v < WARN_TH - HYST) ? 0 : 1;
        return (v < WARN_TH - HYST) ? 0 : (v < FAULT_TH - HYST) ? 1 : 2;
    endfunction

    function automatic logic [12:0] modelVector();
        return {2'(mState), 1'(mState == 1), 1'(mState == 2), 1'(mEvent), 8'(mFaultCount)};
    endfunction

    task automatic modelStep(input int unsigned v, input logic vld, input logic clr);
        int cand;
        mEvent = 0;
`ifdef FAULT_LATCH_EN
        if (clr && mState == 2) begin
            mState = 0;
            mRun   = 0;
            mEvent = 1;
            return;
        end
`endif
        if (!vld) return;
        cand = classify(v, mState);
        if (cand == mState) mRun = 0;
        else if (mRun > 0 && cand == mRunLvl) mRun++;
        else begin
            mRunLvl = cand;
            mRun    = 1;
        end
        if (mRun == N) begin
            mState = mRunLvl;
            mRun   = 0;
            mEvent = 1;
            if (mState == 2 && mFaultCount < 255) mFaultCount++;
        end
    endtask

    // One clock of stimulus; outputs are settled 1 time unit after the edge
    task automatic applyStimulus(input int unsigned v, input logic vld, input logic clr);
        @(negedge clk);
        rms         = v;
        rms_valid   = vld;
        clear_fault = clr;
        @(posedge clk);
        modelStep(v, vld, clr);
        #1;
    endtask

    task automatic doReset();
        #2;
        rms_valid   = 1'b0;
        clear_fault = 1'b0;
        rst         = 1'b1;
        #1;
        mState = 0; mRunLvl = 0; mRun = 0; mEvent = 0; mFaultCount = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nCompared++;
        if (state !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_state got %0d expected 0", state); end
        nCompared++;
        if (warn !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_warn got %b expected 0", warn); end
        nCompared++;
        if (fault !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_fault got %b expected 0", fault); end
        nCompared++;
        if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_event got %b expected 0", event_valid); end
        nCompared++;
        if (fault_count !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_count got %0d expected 0", fault_count); end
    endtask

    task automatic test_warn_entry();
        int unsigned seq [5] = '{1500, 1500, 1500, 1500, 0};
        logic        vld [5] = '{1, 1, 1, 1, 0};
        logic [12:0] act;
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(seq[i], vld[i], 1'b0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL warn_entry step %0d got %h expected %h", i, act, modelVector());
            end
            if (i == 3) begin
                nCompared++;
                if ({state, warn, event_valid} !== 4'b0111) begin
                    nMismatched++;
                    $display("[TB] FAIL warn_entry_edge got %b expected 0111", {state, warn, event_valid});
                end
            end
        end
    endtask

    task automatic test_fault_interrupted();
        int unsigned seq [8] = '{4500, 4500, 4500, 500, 4500, 4500, 4500, 4500};
        logic [12:0] act;
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(seq[i], 1'b1, 1'b0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL fault_interrupted step %0d got %h expected %h", i, act, modelVector());
            end
        end
        nCompared++;
        if ({state, fault_count} !== {2'd2, 8'd1}) begin
            nMismatched++;
            $display("[TB] FAIL fault_interrupted_end got state %0d count %0d expected 2 / 1", state, fault_count);
        end
        applyStimulus(0, 1'b0, 1'b0);
    endtask

    task automatic test_hysteresis();
        int unsigned seq [12] = '{1500, 1500, 1500, 1500, 950, 950, 950, 950, 899, 899, 899, 899};
        logic [12:0] act;
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(seq[i], 1'b1, 1'b0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL hysteresis step %0d got %h expected %h", i, act, modelVector());
            end
            if (i == 7 || i == 11) begin
                nCompared++;
                if (state !== ((i == 7) ? 2'd1 : 2'd0)) begin
                    nMismatched++;
                    $display("[TB] FAIL hysteresis_level step %0d got %0d expected %0d", i, state, (i == 7) ? 1 : 0);
                end
            end
        end
        applyStimulus(0, 1'b0, 1'b0);
    endtask

    task automatic test_fault_exit();
        logic [12:0] act;
        logic [1:0]  want;
        doReset();
        for (int i = 0; i < 10; i++) begin
            if (i < 4)      applyStimulus(4500, 1'b1, 1'b0);
            else if (i < 8) applyStimulus(0, 1'b1, 1'b0);
            else if (i == 8) applyStimulus(4500, 1'b1, 1'b1);
            else            applyStimulus(0, 1'b0, 1'b0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL fault_exit step %0d got %h expected %h", i, act, modelVector());
            end
        end
`ifdef FAULT_LATCH_EN
        want = 2'd0;
`else
        want = 2'd0;
`endif
        nCompared++;
        if (state !== want) begin
            nMismatched++;
            $display("[TB] FAIL fault_exit_end got %0d expected %0d", state, want);
        end
        // Back into FAULT, then a lone acknowledge with no samples
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(4500, 1'b1, 1'b0);
            else       applyStimulus(0, 1'b0, i == 4);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL fault_clear step %0d got %h expected %h", i, act, modelVector());
            end
        end
`ifdef FAULT_LATCH_EN
        want = 2'd0;
`else
        want = 2'd2;
`endif
        nCompared++;
        if (state !== want) begin
            nMismatched++;
            $display("[TB] FAIL fault_clear_end got %0d expected %0d", state, want);
        end
    endtask

    task automatic test_gaps_and_reset();
        logic [12:0] act;
        doReset();
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1500, 1'b1, 1'b0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL gaps strobe %0d got %h expected %h", s, act, modelVector());
            end
            for (int g = 0; g < int'($urandom_range(3, 1)); g++) applyStimulus(0, 1'b0, 1'b0);
        end
        nCompared++;
        if (state !== 2'd1) begin nMismatched++; $display("[TB] FAIL gaps_end got %0d expected 1", state); end
        applyStimulus(4500, 1'b1, 1'b0);
        applyStimulus(4500, 1'b1, 1'b0);
        doReset();
        nCompared++;
        if ({state, warn, fault, event_valid, fault_count} !== 13'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrun_reset got %h expected 0", {state, warn, fault, event_valid, fault_count});
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4500, 1'b1, 1'b0);
            nCompared++;
            if (state !== ((i == 3) ? 2'd2 : 2'd0)) begin
                nMismatched++;
                $display("[TB] FAIL after_reset sample %0d got %0d expected %0d", i, state, (i == 3) ? 2 : 0);
            end
        end
        applyStimulus(0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        logic [12:0] act;
        doReset();
        for (int e = 0; e < 300; e++) begin
            for (int k = 0; k < 4; k++) applyStimulus(4500, 1'b1, 1'b0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL saturation entry %0d got %h expected %h", e, act, modelVector());
            end
`ifdef FAULT_LATCH_EN
            applyStimulus(0, 1'b0, 1'b1);
`else
            for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 1'b0);
`endif
        end
        nCompared++;
        if (fault_count !== 8'd255) begin
            nMismatched++;
            $display("[TB] FAIL saturation_end got %0d expected 255", fault_count);
        end
    endtask

    task automatic test_random();
        int unsigned pick [12] = '{0, 899, 900, 950, 999, 1000, 1500, 3899, 3900, 3999, 4000, 4500};
        int unsigned v;
        logic [12:0] act;
        doReset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(7, 0) == 0) ? $urandom_range(6000, 0) : pick[$urandom_range(11, 0)];
            applyStimulus(v, $urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0);
            act = {state, warn, fault, event_valid, fault_count};
            nCompared++;
            if (act !== modelVector()) begin
                nMismatched++;
                $display("[TB] FAIL random step %0d rms %0d got %h expected %h", i, v, act, modelVector());
            end
        end
    endtask

    initial begin
        test_reset();
        test_warn_entry();
        test_fault_interrupted();
        test_hysteresis();
        test_fault_exit();
        test_gaps_and_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
